// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: receives a length-prefixed, XOR-checksummed
// byte stream, writes the words into imem and releases the core once the load verifies.
module imem_loader #(
    parameter int DEPTH = 51
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    input  logic [31:0] pc_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    output logic        cpu_rst_n_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_loaded_o
);

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(DEPTH);

    state_t      r_state;
    logic [7:0]  r_lenLo;
    logic [15:0] r_len;
    logic [15:0] r_index;
    logic [1:0]  r_byteCnt;
    logic [23:0] r_word;
    logic [7:0]  r_xor;
    logic [31:0] r_waddr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_cpuRstN;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_wordsLoaded;

    logic        w_inStream;
    logic        w_accept;
    logic [15:0] w_count;
    logic [15:0] w_nextIndex;

    assign w_inStream  = (r_state == LEN0) || (r_state == LEN1) ||
                         (r_state == DATA) || (r_state == CSUM);
    assign rx_ready_o  = rst_n && !load_req_i && w_inStream;
    assign w_accept    = rx_valid_i && rx_ready_o;
    assign w_count     = {rx_data_i, r_lenLo};
    assign w_nextIndex = r_index + 16'd1;

    // The write strobe cycle must present the address of the word just completed,
    // even though the index has already advanced.
    assign mem_addr_o = r_we                ? r_waddr :
                        (r_state == DONE)   ? pc_i    :
                        {14'd0, r_index, 2'b00};

    assign mem_we_o       = r_we;
    assign mem_wdata_o    = r_wdata;
    assign cpu_rst_n_o    = r_cpuRstN;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign words_loaded_o = r_wordsLoaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LEN0;
            r_lenLo       <= 8'd0;
            r_len         <= 16'd0;
            r_index       <= 16'd0;
            r_byteCnt     <= 2'd0;
            r_word        <= 24'd0;
            r_xor         <= 8'd0;
            r_waddr       <= 32'd0;
            r_we          <= 1'b0;
            r_wdata       <= 32'd0;
            r_cpuRstN     <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_wordsLoaded <= 16'd0;
        end else begin
            r_we <= 1'b0;
            if (load_req_i) begin
                r_state       <= LEN0;
                r_index       <= 16'd0;
                r_byteCnt     <= 2'd0;
                r_xor         <= 8'd0;
                r_wordsLoaded <= 16'd0;
                r_cpuRstN     <= 1'b0;
                r_done        <= 1'b0;
                r_err         <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    LEN0: begin
                        r_lenLo <= rx_data_i;
                        r_xor   <= r_xor ^ rx_data_i;
                        r_state <= LEN1;
                    end
                    LEN1: begin
                        r_len <= w_count;
                        r_xor <= r_xor ^ rx_data_i;
                        if (w_count > MAX_LEN) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else if (w_count == 16'd0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_xor     <= r_xor ^ rx_data_i;
                        r_byteCnt <= r_byteCnt + 2'd1;
                        // Bytes arrive LSB first, so shift each new byte in at the top.
                        if (r_byteCnt == 2'd3) begin
                            r_we          <= 1'b1;
                            r_wdata       <= {rx_data_i, r_word};
                            r_waddr       <= {14'd0, r_index, 2'b00};
                            r_index       <= w_nextIndex;
                            r_wordsLoaded <= r_wordsLoaded + 16'd1;
                            if (w_nextIndex == r_len) begin
                                r_state <= CSUM;
                            end
                        end else begin
                            r_word <= {rx_data_i, r_word[23:8]};
                        end
                    end
                    CSUM: begin
                        if (rx_data_i == r_xor) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_cpuRstN <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time programming controller for the pipeline's instruction memory. Accepts a byte stream (length, instruction words, checksum) over a valid/ready port and writes the words into the instruction memory write port. Holds the core in reset until a load completes with a good checksum. After the load, it passes the fetch-stage PC through to the memory address.

## Interface
- `DEPTH`, default 51: instruction memory depth in 32-bit words; the maximum legal word count.
- `clk`  in  1  — rising-edge clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `load_req_i`  in  1  — synchronous restart pulse; aborts any load and starts a new one.
- `rx_valid_i`  in  1  — a stream byte is presented.
- `rx_data_i`  in  8  — stream byte.
- `rx_ready_o`  out  1  — loader accepts the byte this cycle.
- `pc_i`  in  32  — fetch-stage PC.
- `mem_addr_o`  out  32  — byte address to the instruction memory.
- `mem_we_o`  out  1  — single-cycle word write strobe.
- `mem_wdata_o`  out  32  — write data.
- `cpu_rst_n_o`  out  1  — active-low reset to the pipeline; registered.
- `done_o`  out  1  — load completed and checksum matched.
- `err_o`  out  1  — load failed (oversize count or bad checksum).
- `words_loaded_o`  out  16  — number of words written in the current load.

## Operation
- **Stream format**, in order:
  - `LEN_LO`, `LEN_HI`: 16-bit word count N, little-endian.
  - N×4 data bytes, each word little-endian (first byte = bits [7:0]).
  - One `CSUM` byte: XOR of every preceding byte, including both length bytes.
- **Handshake:** a byte transfers on a rising edge where `rx_valid_i && rx_ready_o`. `rx_ready_o` is combinational:
  - 1 in `LEN0`, `LEN1`, `DATA` and `CSUM`;
  - 0 in `DONE` and `ERR`;
  - forced to 0 in any cycle where `load_req_i` = 1.
- **FSM states:** `LEN0`, `LEN1`, `DATA`, `CSUM`, `DONE`, `ERR`.
- **Transitions:**
  - `LEN0` → `LEN1` on accept.
  - `LEN1` on accept:
    - count > `DEPTH` → `ERR`;
    - count = 0 → `CSUM`;
    - otherwise → `DATA`.
  - `DATA`: a 2-bit byte counter assembles bytes into a word register. On the 4th byte the word is written and the word index incremented. When the index reaches N → `CSUM`.
  - `CSUM` on accept: byte equals running XOR → `DONE`; otherwise → `ERR`.
  - `DONE` and `ERR` hold until `load_req_i` or reset.
- **Write port:**
  - `mem_we_o`/`mem_wdata_o` are registered and asserted for exactly one cycle, the cycle after the 4th byte is accepted.
  - During that cycle `mem_addr_o` = word_index×4, using the index before its increment.
- **Address mux:**
  - In `DONE`, `mem_addr_o` = `pc_i` (combinational passthrough).
  - In all other states, `mem_addr_o` = current word_index×4.
- **Load counter:** `words_loaded_o` increments on each write; it saturates naturally at N ≤ `DEPTH`.
- **`load_req_i`:** in any state, the next state is `LEN0`. Word index, byte counter, XOR accumulator, `words_loaded_o`, `done_o` and `err_o` clear to 0, and `cpu_rst_n_o` goes to 0 at the next edge.
  - A pending write strobe still completes; `mem_we_o` is not cancelled.
  - If `load_req_i` and a byte handshake would coincide, `load_req_i` wins and no byte is taken.

## Timing
- **Reset values (async, while `rst_n` = 0):**
  - state = `LEN0`;
  - `mem_we_o` = 0, `mem_wdata_o` = 0;
  - `cpu_rst_n_o` = 0, `done_o` = 0, `err_o` = 0;
  - `words_loaded_o` = 0, index/XOR = 0;
  - `rx_ready_o` = 0 while `rst_n` is low.
- **Write latency:** 1 cycle from the 4th byte accept to `mem_we_o`.
- **Completion:** `done_o` and `cpu_rst_n_o` rise one cycle after the `CSUM` byte accept.
- **Failure:**
  - `err_o` rises one cycle after the offending `LEN_HI` or `CSUM` accept;
  - `cpu_rst_n_o` stays 0 in `ERR`.
- **Throughput:** one byte per cycle sustained; a 4-byte word costs 4 cycles; gaps in `rx_valid_i` stall without state change.
- **Reset mid-load:** everything is lost; the loader restarts at `LEN0`.

## Test plan
- **Normal load:** N = 2 (bytes `02 00`), words `0x00500093` and `0x00A00113`, then correct CSUM → writes at addr 0 and 4 with those data, each one cycle. `done_o` = 1, `cpu_rst_n_o` = 1, `words_loaded_o` = 2, and `mem_addr_o` then tracks `pc_i` = `0x8` → `0x8`.
- **Bad checksum:** same stream with CSUM XOR `0x01` → `err_o` = 1, `done_o` = 0, `cpu_rst_n_o` = 0, `rx_ready_o` = 0.
- **Oversize:** `LEN` = 52 (`34 00`) with `DEPTH` = 51 → `ERR` one cycle after `LEN_HI`, and no `mem_we_o` pulse.
- **Zero length:** bytes `00 00 00` → `DONE`, no writes, `words_loaded_o` = 0.
- **Stalls and restart:**
  - Random `rx_valid_i` gaps during the first load → identical writes.
  - `load_req_i` after the 5th data byte → `LEN0` and counters cleared.
  - The byte presented in the `load_req_i` cycle is not accepted.
  - A fresh N = 1 load then writes addr 0 and reaches `DONE`.
- **Async reset mid-`DATA`:** all outputs return to reset values immediately; the following full load succeeds.
